// File: rtl/queens_backtrack_sequencer.sv
// Depth-first N-queens search sequencer. It drives an external occupancy datapath through
// probe/place/remove commands, places one queen per row, and hands each complete placement
// to the consumer through a hold-until-acknowledged handshake.
module queens_backtrack_sequencer #(
  parameter int unsigned N     = 8,
  parameter int unsigned COL_W = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_is_safe,
  output logic [COL_W-1:0]   o_row,
  output logic [COL_W-1:0]   o_col,
  output logic               o_place_queen,
  output logic               o_remove_queen,
  output logic               o_clear_board,
  output logic               o_busy,
  output logic               o_sol_valid,
  input  logic               i_sol_next,
  output logic [N*COL_W-1:0] o_sol_cols,
  output logic [CNT_W-1:0]   o_sol_count,
  output logic               o_done
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StProbe,
    StPlace,
    StBacktrack,
    StRemove,
    StSolved,
    StFinish
  } state_e;

  localparam logic [COL_W-1:0] LastIdx = COL_W'(N - 1);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [COL_W-1:0]         r_row;
  logic [COL_W-1:0]         r_col;
  logic [N-1:0][COL_W-1:0]  r_colpos;
  logic [CNT_W-1:0]         r_sol_count;
  logic                     r_place;
  logic                     r_remove;
  logic                     r_clear;
  logic                     r_busy;
  logic                     r_sol_valid;
  logic                     r_done;

  logic w_last_col;
  logic w_last_row;
  logic w_row_zero;

  assign w_last_col = (r_col == LastIdx);
  assign w_last_row = (r_row == LastIdx);
  assign w_row_zero = (r_row == '0);

  // Next-state selection; is_safe is only meaningful while probing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:      if (i_start) w_state_nxt = StClear;
      StClear:     w_state_nxt = StProbe;
      StProbe: begin
        if (i_is_safe)      w_state_nxt = StPlace;
        else if (w_last_col) w_state_nxt = StBacktrack;
      end
      StPlace:     w_state_nxt = w_last_row ? StSolved : StProbe;
      StBacktrack: w_state_nxt = w_row_zero ? StFinish : StRemove;
      StRemove:    w_state_nxt = w_last_col ? StBacktrack : StProbe;
      StSolved:    if (i_sol_next) w_state_nxt = StRemove;
      StFinish:    w_state_nxt = StIdle;
      default:     w_state_nxt = StIdle;
    endcase
  end

  // State, search cursor, per-row placement record and registered command outputs.
  // Command strobes are decoded from the next state so they are high exactly while the
  // machine sits in the matching state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_row       <= '0;
      r_col       <= '0;
      r_colpos    <= '0;
      r_sol_count <= '0;
      r_place     <= 1'b0;
      r_remove    <= 1'b0;
      r_clear     <= 1'b0;
      r_busy      <= 1'b0;
      r_sol_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != StIdle);
      r_clear     <= (w_state_nxt == StClear);
      r_place     <= (w_state_nxt == StPlace);
      r_remove    <= (w_state_nxt == StRemove);
      r_sol_valid <= (w_state_nxt == StSolved);
      r_done      <= (w_state_nxt == StFinish);
      case (r_state)
        StIdle: if (i_start) r_sol_count <= '0;
        StClear: begin
          r_row <= '0;
          r_col <= '0;
        end
        StProbe: if (!i_is_safe && !w_last_col) r_col <= r_col + 1'b1;
        StPlace: begin
          r_colpos[r_row] <= r_col;
          if (w_last_row) begin
            if (r_sol_count != '1) r_sol_count <= r_sol_count + 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
            r_col <= '0;
          end
        end
        StBacktrack: begin
          // Step back one row and reload that row's queen so REMOVE can lift it.
          if (!w_row_zero) begin
            r_row <= r_row - 1'b1;
            r_col <= r_colpos[r_row - 1'b1];
          end
        end
        StRemove: if (!w_last_col) r_col <= r_col + 1'b1;
        StSolved: begin
          if (i_sol_next) begin
            r_row <= LastIdx;
            r_col <= r_colpos[LastIdx];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_row          = r_row;
  assign o_col          = r_col;
  assign o_place_queen  = r_place;
  assign o_remove_queen = r_remove;
  assign o_clear_board  = r_clear;
  assign o_busy         = r_busy;
  assign o_sol_valid    = r_sol_valid;
  assign o_sol_cols     = r_colpos;
  assign o_sol_count    = r_sol_count;
  assign o_done         = r_done;

endmodule
